data_mem_mmio: RTL and testbench
================================

Name: data_mem_mmio

Overview:
- Data-side memory stage directly downstream of the single-cycle core datapath.
- Consumes the core's effective address (ALU result), byte-lane-aligned store data and write mask.
- Returns load data in the same cycle, so the datapath's byte/halfword extraction completes within the instruction.
- Maps a byte-enabled word RAM plus an MMIO page containing an LED register, a free-running cycle counter and a FIFO-buffered 8N1 UART transmitter.

Parameters:
RAM_WORDS, 1024, RAM depth in 32-bit words (power of two).
FIFO_DEPTH, 8, UART TX FIFO entries (power of two, >=2).
CLK_DIV, 868, clock cycles per UART bit.

Ports:
clk  in  1  system clock, all state updates on posedge.
reset  in  1  synchronous, active-high reset.
memAddr  in  32  byte address from datapath ALU output.
memWdata  in  32  store data, already replicated onto byte lanes.
memWMask  in  4  byte write enables; 0 means no write.
memRdata  out  32  combinational read data for memAddr.
leds  out  8  LED register contents.
uartTx  out  1  serial transmit line, idle high.

Behaviour:
- Decode: memAddr[31]=0 selects RAM. memAddr[31]=1 selects MMIO; register chosen by memAddr[4:2], other address bits ignored.
- RAM:
  - Word index is memAddr[log2(RAM_WORDS)+1:2]; higher bits are ignored, so addresses alias modulo RAM size.
  - Read is combinational (asynchronous).
  - Write on posedge: each lane i is written iff memWMask[i].
  - RAM contents are not cleared by reset.
- MMIO map, offset from 0x8000_0000:
  - 0x00 LED: R/W. Bits 7:0 written when memWMask[0]. Reads {24'b0, leds}.
  - 0x04 TXDATA: write with memWMask[0] pushes memWdata[7:0] into the FIFO. Reads 0.
  - 0x08 STATUS: bit0 fifoFull, bit1 fifoEmpty, bit2 txBusy, bit3 overflow (sticky). Write with memWMask[0] and memWdata[3]=1 clears overflow. Other bits read 0.
  - 0x0C CYCLE: read-only 32-bit counter; +1 every cycle, wraps 0xFFFF_FFFF->0. Writes ignored.
  - 0x10-0x1C: read 0, writes ignored.
- Reads always return pre-edge state: a same-cycle write is not visible until the next cycle.
- FIFO:
  - Circular buffer with read/write pointers and count.
  - Push is accepted iff count<FIFO_DEPTH before the edge. A push when full is dropped and sets overflow, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
  - Pointers wrap at FIFO_DEPTH.
  - A set-overflow event and a clear-overflow write in the same cycle: set wins.
- UART TX FSM, states IDLE, START, DATA, STOP; bit timer counts CLK_DIV cycles per state bit.
  - IDLE: uartTx=1. If FIFO non-empty: pop the head into the shift register, clear the timer and bit index, go to START.
  - START: uartTx=0 for CLK_DIV cycles, then DATA.
  - DATA: uartTx=shift[0] (LSB first). After CLK_DIV cycles, shift right; after the 8th bit go to STOP.
  - STOP: uartTx=1 for CLK_DIV cycles, then IDLE.
  - Back-to-back frames have exactly one IDLE cycle between the stop bit and the next start bit.
  - txBusy = (state != IDLE).
  - Frame length is 10*CLK_DIV cycles.
- Reset values: leds=0, CYCLE=0, FIFO empty (pointers and count 0), overflow=0, FSM IDLE, uartTx=1, timers 0. Reset asserted mid-frame aborts the frame: uartTx is 1 in the cycle after the reset edge and pending FIFO data is discarded.
- Width rules: all counters are unsigned. The bit timer is sized ceil(log2(CLK_DIV)) and compares against CLK_DIV-1.

Test Plan:
Bench runs with CLK_DIV=4, FIFO_DEPTH=4, RAM_WORDS=256.
1. RAM byte lanes: write 0xAABBCCDD mask 4'b1111 to 0x10, then 0x00EE0000 mask 4'b0100 to 0x10 -> read 0x10 = 0xAAEECCDD; read 0x410 aliases to the same word.
2. Same-cycle visibility: write LED 0x5A and read 0x8000_0000 in the same cycle -> old value 0x00; next cycle reads 0x0000005A; leds=0x5A.
3. Single frame: push 0xA5 -> uartTx pattern 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; txBusy=1 for 40 cycles; STATUS=0x2 afterward.
4. Overflow: push 6 bytes in consecutive cycles -> first byte popped in the cycle after its push, FIFO then fills to 4. STATUS reads bit0=1 at the first failing push, bit3=1 after it. Write 0x8 to STATUS -> bit3 clears. Exactly 5 frames are transmitted, with 1 idle cycle between frames.
5. CYCLE: read 0x8000_000C at cycles 10 and 20 after reset release -> difference 10. Force the counter to 0xFFFF_FFFF -> next cycle reads 0.
6. Reset mid-frame: assert reset during the DATA state with 2 bytes queued -> uartTx=1, STATUS=0x2, leds=0, and no further frames are sent.

Source files
------------

// File: rtl/data_mem_mmio_if.sv
// data_mem_mmio_if: datapath-to-memory bus carrying the address, store data, byte mask and load data.
interface data_mem_mmio_if;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memWMask;
    logic [31:0] memRdata;
    modport master(output memAddr, memWdata, memWMask, input memRdata);
    modport slave(input memAddr, memWdata, memWMask, output memRdata);
endinterface

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: byte-enabled word RAM with async read plus an MMIO page (LEDs, cycle counter, FIFO-fed 8N1 UART TX).
module data_mem_mmio #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 868
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_mmio_if.slave        bus,
    output logic [7:0]            leds,
    output logic                  uartTx
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic [31:0]   cycle_q;
    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          pop, tick;

    logic          is_mmio, lane0, full, empty, busy;
    logic          led_wr, push_req, push_ok, push_drop, clr_ovf;
    logic [2:0]    sel;
    logic [AW-1:0] idx;
    logic [31:0]   status, mmio_rd;
    logic          unused_addr;

    assign is_mmio   = bus.memAddr[31];
    assign sel       = bus.memAddr[4:2];
    assign idx       = bus.memAddr[AW+1:2];
    assign lane0     = bus.memWMask[0];
    assign unused_addr = ^bus.memAddr;

    assign full      = count == CW'(FIFO_DEPTH);
    assign empty     = count == '0;
    assign busy      = state != IDLE;
    assign led_wr    = is_mmio && sel == 3'd0 && lane0;
    assign push_req  = is_mmio && sel == 3'd1 && lane0;
    assign push_ok   = push_req && !full;
    assign push_drop = push_req && full;
    assign clr_ovf   = is_mmio && sel == 3'd2 && lane0 && bus.memWdata[3];

    assign status  = {28'b0, ovf, busy, empty, full};
    assign mmio_rd = sel == 3'd0 ? {24'b0, leds} :
                     sel == 3'd2 ? status :
                     sel == 3'd3 ? cycle_q : 32'b0;
    assign bus.memRdata = is_mmio ? mmio_rd : ram[idx];

    assign uartTx = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    assign tick   = timer == TW'(CLK_DIV - 1);

    // RAM contents survive reset, so the array has its own reset-free process
    always_ff @(posedge clk) begin
        if (!is_mmio)
            for (int i = 0; i < 4; i++)
                if (bus.memWMask[i]) ram[idx][8*i +: 8] <= bus.memWdata[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo[wr_ptr] <= bus.memWdata[7:0];
    end

    always_comb begin
        state_n = state;
        timer_n = timer + 1'b1;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = fifo[rd_ptr];
                    bit_n   = '0;
                    state_n = START;
                end
            end
            START: if (tick) begin
                timer_n = '0;
                state_n = DATA;
            end
            DATA: if (tick) begin
                timer_n = '0;
                shift_n = shift >> 1;
                bit_n   = bit_idx + 3'd1;
                state_n = bit_idx == 3'd7 ? STOP : DATA;
            end
            STOP: if (tick) begin
                timer_n = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // a dropped push sets overflow even when a clear lands in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            leds    <= '0;
            cycle_q <= '0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            wr_ptr  <= wr_ptr + PW'(push_ok);
            rd_ptr  <= rd_ptr + PW'(pop);
            count   <= count + CW'(push_ok) - CW'(pop);
            ovf     <= push_drop | (ovf & ~clr_ovf);
            leds    <= led_wr ? bus.memWdata[7:0] : leds;
            cycle_q <= cycle_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: directed checks of RAM lanes, MMIO registers, UART framing, FIFO overflow and reset abort.
module tb_data_mem_mmio;
    localparam int CD = 4, FD = 4, RW = 256;
    localparam logic [31:0] LED = 32'h8000_0000, TXD = 32'h8000_0004;
    localparam logic [31:0] STAT = 32'h8000_0008, CYC = 32'h8000_000C;

    logic clk = 1'b0, reset = 1'b1;
    logic [7:0] leds;
    logic uart_tx, last_tx;
    logic [31:0] rd, c1, c2;
    logic [39:0] seq;
    logic [9:0] frame;
    int n_cmp = 0, n_err = 0, busy;

    data_mem_mmio_if bus();
    data_mem_mmio #(.RAM_WORDS(RW), .FIFO_DEPTH(FD), .CLK_DIV(CD)) dut (
        .clk(clk), .reset(reset), .bus(bus), .leds(leds), .uartTx(uart_tx)
    );

    always #5 clk = ~clk;

    // serial line decoder: start-bit edges and bytes sampled mid-bit
    int tb_cyc = 0, pos = 0, frame_err = 0;
    bit active = 1'b0;
    logic [7:0] rx_b;
    logic [7:0] rx_q[$];
    int starts[$];
    always @(negedge clk) begin
        if (reset) active = 1'b0;
        else if (!active) begin
            if (uart_tx === 1'b0) begin
                active = 1'b1;
                pos = 0;
                rx_b = '0;
                starts.push_back(tb_cyc);
            end
        end else begin
            pos++;
            if (pos >= 6 && pos <= 34 && (pos - 6) % 4 == 0) rx_b[(pos-6)/4] = uart_tx;
            if (pos == 38 && uart_tx !== 1'b1) frame_err++;
            if (pos == 39) begin
                active = 1'b0;
                rx_q.push_back(rx_b);
            end
        end
        tb_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // one bus cycle; returns the read data seen before the edge
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, output logic [31:0] r);
        bus.memAddr = a;
        bus.memWdata = d;
        bus.memWMask = m;
        @(negedge clk);
        r = bus.memRdata;
        last_tx = uart_tx;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.memAddr = '0;
        bus.memWdata = '0;
        bus.memWMask = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        access(CYC, 0, 0, rd);
        check("cycle_reset", rd, 0);
        check("tx_idle_reset", {31'b0, last_tx}, 1);
        check("leds_reset", {24'b0, leds}, 0);
        access(STAT, 0, 0, rd);
        check("status_reset", rd, 32'h2);
        access(LED, 0, 0, rd);
        check("led_reg_reset", rd, 0);

        access(CYC, 0, 0, c1);
        access(CYC, 32'h1234, 4'hF, rd);
        repeat (8) access(0, 0, 0, rd);
        access(CYC, 0, 0, c2);
        check("cycle_delta", c2 - c1, 10);
        bus.memAddr = CYC;
        bus.memWMask = 4'h0;
        force dut.cycle_q = 32'hFFFF_FFFF;
        #2 check("cycle_forced", bus.memRdata, 32'hFFFF_FFFF);
        release dut.cycle_q;
        access(CYC, 0, 0, rd);
        access(CYC, 0, 0, rd);
        check("cycle_wrap", rd, 0);

        access(32'h10, 32'hAABB_CCDD, 4'b1111, rd);
        access(32'h10, 32'h00EE_0000, 4'b0100, rd);
        access(32'h10, 32'hFFFF_FFFF, 4'b0000, rd);
        check("ram_lanes", rd, 32'hAAEE_CCDD);
        access(32'h410, 0, 0, rd);
        check("ram_alias", rd, 32'hAAEE_CCDD);
        access(32'h8000_0010, 32'h1111_1111, 4'hF, rd);
        access(32'h8000_0010, 0, 0, rd);
        check("mmio_reserved", rd, 0);
        access(32'h10, 0, 0, rd);
        check("ram_untouched", rd, 32'hAAEE_CCDD);

        access(LED, 32'h5A, 4'b0001, rd);
        check("led_same_cycle", rd, 0);
        access(LED, 32'hFF, 4'b1110, rd);
        check("led_next_cycle", rd, 32'h5A);
        check("leds_port", {24'b0, leds}, 32'h5A);

        rx_q.delete();
        starts.delete();
        access(TXD, 32'hA5, 4'b0001, rd);
        busy = 0;
        seq = '0;
        for (int i = 0; i < 45; i++) begin
            access(STAT, 0, 0, rd);
            if (rd[2]) begin
                busy++;
                if (busy <= 40) seq[busy-1] = last_tx;
            end
        end
        check("busy_cycles", busy, 40);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++)
            check($sformatf("frame_bit%0d", b), {28'b0, seq[4*b +: 4]}, {28'b0, {4{frame[b]}}});
        check("status_after_frame", rd, 32'h2);
        check("rx_count_single", rx_q.size(), 1);
        if (rx_q.size() > 0) check("rx_byte_single", {24'b0, rx_q[0]}, 32'hA5);

        rx_q.delete();
        starts.delete();
        for (int k = 0; k < 6; k++) access(TXD, 32'h11 * (k + 1), 4'b0001, rd);
        access(STAT, 0, 0, rd);
        check("status_overflow", rd, 32'hD);
        access(STAT, 32'h8, 4'b0001, rd);
        check("status_pre_clear", rd, 32'hD);
        access(STAT, 0, 0, rd);
        check("status_cleared", rd, 32'h5);
        repeat (230) access(0, 0, 0, rd);
        check("frames_sent", starts.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < rx_q.size()) check($sformatf("rx_byte%0d", i), {24'b0, rx_q[i]}, 32'h11 * (i + 1));
        for (int i = 1; i < 5; i++)
            if (i < starts.size()) check($sformatf("frame_gap%0d", i), starts[i] - starts[i-1], 41);
        access(STAT, 0, 0, rd);
        check("status_drained", rd, 32'h2);

        access(TXD, 32'h77, 4'b0001, rd);
        access(TXD, 32'h88, 4'b0001, rd);
        access(TXD, 32'h99, 4'b0001, rd);
        repeat (8) access(0, 0, 0, rd);
        access(STAT, 0, 0, rd);
        check("status_midframe", rd, 32'h4);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        rx_q.delete();
        starts.delete();
        access(STAT, 0, 0, rd);
        check("status_after_reset", rd, 32'h2);
        check("tx_after_reset", {31'b0, last_tx}, 1);
        check("leds_after_reset", {24'b0, leds}, 0);
        repeat (120) access(0, 0, 0, rd);
        check("frames_after_reset", starts.size(), 0);
        check("stop_bits", frame_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
